// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU fetch-control definitions: PC select codes, sequencer FSM
// states and the NOP encoding inserted by the IF stage on a kill.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'd0,  // PC+1
        PC_JMP = 2'd1,  // J-type target (JMP and CALL)
        PC_BR  = 2'd2,  // I-type target (taken branch)
        PC_RET = 2'd3   // ReturnAddress from the RAS
    } pcsrc_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } seq_state_e;

    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry; a pop on an empty stack leaves it empty. Both cases latch a
// sticky error flag that only reset clears.
module ras_stack
    import fetch_sequencer_pkg::*;
#(
    parameter int RAS_DEPTH = 4,
    parameter int AW        = 16,
    localparam int PW       = $clog2(RAS_DEPTH),
    localparam int CW       = $clog2(RAS_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_addr,
    output logic [AW-1:0] top,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [AW-1:0] ent_q [RAS_DEPTH];
    logic [AW-1:0] ent_d [RAS_DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;      // next free slot; top is ptr_q-1
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [PW-1:0] top_idx;

    assign top_idx = ptr_q - PW'(1);

    // Next-state for pointer, count, flags and entry array; pop wins a tie
    always_comb begin
        ent_d = ent_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (pop) begin
            if (cnt_q == '0) begin
                unf_d = 1'b1;
            end else begin
                ptr_d = top_idx;
                cnt_d = cnt_q - CW'(1);
            end
        end else if (push) begin
            ent_d[ptr_q] = push_addr;
            ptr_d        = ptr_q + PW'(1);
            if (cnt_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Control state, asynchronously cleared
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage; contents are don't-care while count is zero
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign top       = (cnt_q == '0) ? '0 : ent_q[top_idx];
    assign count     = cnt_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: picks the next-PC source from the ID-stage control class,
// kills the wrong-path IF instruction on redirects, and inserts a single
// cycle load-use stall that defers any redirect to the following cycle.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int RAS_DEPTH = 4,
    parameter int AW        = 16,
    localparam int CW       = $clog2(RAS_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          id_valid,
    input  logic          id_is_jmp,
    input  logic          id_is_call,
    input  logic          id_is_ret,
    input  logic          id_is_branch,
    input  logic          branch_taken,
    input  logic [AW-1:0] id_npc,
    input  logic          load_use_hazard,
    output logic [1:0]    PCsrc,
    output logic          stall,
    output logic          kill,
    output logic [AW-1:0] ReturnAddress,
    output logic [CW-1:0] ras_count,
    output logic          ras_overflow,
    output logic          ras_underflow
);

    seq_state_e    state_q, state_d;
    pcsrc_e        pcsrc_c;
    logic          stall_c, kill_c;
    logic          push, pop;
    logic [AW-1:0] ras_top;

    // State register; HOLD marks that the last cycle was a load-use stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Mealy redirect decision; ret > call > jmp > branch
    always_comb begin
        state_d = ST_RUN;
        stall_c = 1'b0;
        kill_c  = 1'b0;
        pcsrc_c = PC_SEQ;
        push    = 1'b0;
        pop     = 1'b0;
        if (state_q == ST_RUN && load_use_hazard) begin
            stall_c = 1'b1;
            state_d = ST_HOLD;
        end else if (id_valid) begin
            if (id_is_ret) begin
                pcsrc_c = PC_RET;
                kill_c  = 1'b1;
                pop     = 1'b1;
            end else if (id_is_call) begin
                pcsrc_c = PC_JMP;
                kill_c  = 1'b1;
                push    = 1'b1;
            end else if (id_is_jmp) begin
                pcsrc_c = PC_JMP;
                kill_c  = 1'b1;
            end else if (id_is_branch && branch_taken) begin
                pcsrc_c = PC_BR;
                kill_c  = 1'b1;
            end
        end
    end

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .AW        (AW)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .push_addr (id_npc),
        .top       (ras_top),
        .count     (ras_count),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    // Outputs are held quiet while reset is asserted
    assign stall         = reset_n & stall_c;
    assign kill          = reset_n & kill_c;
    assign PCsrc         = reset_n ? pcsrc_c : PC_SEQ;
    assign ReturnAddress = reset_n ? ras_top : '0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: inputs change on the falling edge,
// outputs are checked 1 ns later, state updates on the rising edge.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid, id_is_jmp, id_is_call, id_is_ret, id_is_branch;
    logic        branch_taken, load_use_hazard;
    logic [15:0] id_npc;
    logic [1:0]  PCsrc;
    logic        stall, kill;
    logic [15:0] ReturnAddress;
    logic [2:0]  ras_count;
    logic        ras_overflow, ras_underflow;

    int vecs = 0;
    int errs = 0;

    fetch_sequencer #(.RAS_DEPTH(4), .AW(16)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_valid        (id_valid),
        .id_is_jmp       (id_is_jmp),
        .id_is_call      (id_is_call),
        .id_is_ret       (id_is_ret),
        .id_is_branch    (id_is_branch),
        .branch_taken    (branch_taken),
        .id_npc          (id_npc),
        .load_use_hazard (load_use_hazard),
        .PCsrc           (PCsrc),
        .stall           (stall),
        .kill            (kill),
        .ReturnAddress   (ReturnAddress),
        .ras_count       (ras_count),
        .ras_overflow    (ras_overflow),
        .ras_underflow   (ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one ID-stage instruction; v,ret,call,jmp,br,tk,hz,npc
    task automatic drive(input logic v, input logic r, input logic c, input logic j,
                         input logic b, input logic t, input logic h, input logic [15:0] n);
        id_valid = v; id_is_ret = r; id_is_call = c; id_is_jmp = j;
        id_is_branch = b; branch_taken = t; load_use_hazard = h; id_npc = n;
    endtask

    // Advance to the next falling edge (one rising edge in between)
    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
        reset_n = 1'b0;
        #3;
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_kill", {31'b0, kill}, 0);
        chk("rst_pcsrc", {30'b0, PCsrc}, 0);
        chk("rst_ra", {16'b0, ReturnAddress}, 0);
        chk("rst_cnt", {29'b0, ras_count}, 0);
        chk("rst_ovf", {31'b0, ras_overflow}, 0);
        chk("rst_unf", {31'b0, ras_underflow}, 0);
        nxt();
        reset_n = 1'b1;

        // CALL 0x0012 then RET
        nxt(); drive(1, 0, 1, 0, 0, 0, 0, 16'h0012); #1;
        chk("call_pcsrc", {30'b0, PCsrc}, 1);
        chk("call_kill", {31'b0, kill}, 1);
        nxt(); drive(0, 0, 0, 0, 0, 0, 0, 16'h0); #1;
        chk("call_cnt", {29'b0, ras_count}, 1);
        chk("call_ra", {16'b0, ReturnAddress}, 16'h0012);
        nxt(); drive(1, 1, 0, 0, 0, 0, 0, 16'h0); #1;
        chk("ret_pcsrc", {30'b0, PCsrc}, 3);
        chk("ret_ra", {16'b0, ReturnAddress}, 16'h0012);
        chk("ret_kill", {31'b0, kill}, 1);
        nxt(); drive(0, 0, 0, 0, 0, 0, 0, 16'h0); #1;
        chk("ret_cnt", {29'b0, ras_count}, 0);
        chk("ret_ra0", {16'b0, ReturnAddress}, 0);

        // Load-use with JMP: one stall cycle, then the JMP redirects
        nxt(); drive(1, 0, 0, 1, 0, 0, 1, 16'h0); #1;
        chk("lu1_stall", {31'b0, stall}, 1);
        chk("lu1_pcsrc", {30'b0, PCsrc}, 0);
        chk("lu1_kill", {31'b0, kill}, 0);
        nxt(); #1;
        chk("lu2_stall", {31'b0, stall}, 0);
        chk("lu2_pcsrc", {30'b0, PCsrc}, 1);
        chk("lu2_kill", {31'b0, kill}, 1);
        // Load-use with CALL: stack must not move during the stall cycle
        nxt(); drive(1, 0, 1, 0, 0, 0, 1, 16'h00AA); #1;
        chk("lu_call_stall", {31'b0, stall}, 1);
        nxt(); drive(0, 0, 0, 0, 0, 0, 0, 16'h0); #1;
        chk("lu_call_cnt", {29'b0, ras_count}, 0);
        chk("lu_call_stall_off", {31'b0, stall}, 0);

        // Five CALLs into a 4-deep stack
        for (int i = 1; i <= 5; i++) begin
            nxt(); drive(1, 0, 1, 0, 0, 0, 0, 16'(i));
        end
        nxt(); drive(0, 0, 0, 0, 0, 0, 0, 16'h0); #1;
        chk("ovf_flag", {31'b0, ras_overflow}, 1);
        chk("ovf_cnt", {29'b0, ras_count}, 4);
        chk("ovf_unf", {31'b0, ras_underflow}, 0);
        for (int i = 5; i >= 2; i--) begin
            nxt(); drive(1, 1, 0, 0, 0, 0, 0, 16'h0); #1;
            chk("pop_ra", {16'b0, ReturnAddress}, 32'(i));
            chk("pop_pcsrc", {30'b0, PCsrc}, 3);
        end
        nxt(); drive(0, 0, 0, 0, 0, 0, 0, 16'h0); #1;
        chk("pop_cnt", {29'b0, ras_count}, 0);

        // RET on empty stack
        nxt(); drive(1, 1, 0, 0, 0, 0, 0, 16'h0); #1;
        chk("unf_pcsrc", {30'b0, PCsrc}, 3);
        chk("unf_ra", {16'b0, ReturnAddress}, 0);
        nxt(); drive(0, 0, 0, 0, 0, 0, 0, 16'h0); #1;
        chk("unf_flag", {31'b0, ras_underflow}, 1);
        chk("unf_cnt", {29'b0, ras_count}, 0);
        nxt(); nxt(); #1;
        chk("unf_sticky", {31'b0, ras_underflow}, 1);
        chk("ovf_sticky", {31'b0, ras_overflow}, 1);

        // Priority and qualification
        nxt(); drive(1, 1, 1, 1, 1, 1, 0, 16'h0033); #1;
        chk("pri_ret", {30'b0, PCsrc}, 3);
        nxt(); drive(1, 0, 1, 1, 1, 1, 0, 16'h0044); #1;
        chk("pri_call", {30'b0, PCsrc}, 1);
        nxt(); drive(1, 0, 0, 1, 1, 1, 0, 16'h0); #1;
        chk("pri_jmp", {30'b0, PCsrc}, 1);
        chk("pri_call_cnt", {29'b0, ras_count}, 1);
        chk("pri_call_ra", {16'b0, ReturnAddress}, 16'h0044);
        nxt(); drive(0, 0, 1, 0, 0, 0, 0, 16'h0055); #1;
        chk("inv_pcsrc", {30'b0, PCsrc}, 0);
        chk("inv_kill", {31'b0, kill}, 0);
        nxt(); drive(1, 0, 0, 0, 1, 1, 0, 16'h0); #1;
        chk("inv_cnt", {29'b0, ras_count}, 1);
        chk("br_t_pcsrc", {30'b0, PCsrc}, 2);
        chk("br_t_kill", {31'b0, kill}, 1);
        nxt(); drive(1, 0, 0, 0, 1, 0, 0, 16'h0); #1;
        chk("br_nt_pcsrc", {30'b0, PCsrc}, 0);
        chk("br_nt_kill", {31'b0, kill}, 0);

        // Build 3 entries, then reset mid-cycle
        nxt(); drive(1, 0, 1, 0, 0, 0, 0, 16'h0061);
        nxt(); drive(1, 0, 1, 0, 0, 0, 0, 16'h0062);
        nxt(); drive(1, 1, 0, 0, 0, 0, 0, 16'h0); #1;
        chk("pre_rst_cnt", {29'b0, ras_count}, 3);
        chk("pre_rst_ra", {16'b0, ReturnAddress}, 16'h0062);
        #1 reset_n = 1'b0; #1;
        chk("mid_rst_cnt", {29'b0, ras_count}, 0);
        chk("mid_rst_ra", {16'b0, ReturnAddress}, 0);
        chk("mid_rst_kill", {31'b0, kill}, 0);
        chk("mid_rst_pcsrc", {30'b0, PCsrc}, 0);
        chk("mid_rst_ovf", {31'b0, ras_overflow}, 0);
        chk("mid_rst_unf", {31'b0, ras_underflow}, 0);
        nxt(); reset_n = 1'b1; drive(1, 0, 1, 0, 0, 0, 0, 16'h0077);
        nxt(); drive(0, 0, 0, 0, 0, 0, 0, 16'h0); #1;
        chk("post_rst_cnt", {29'b0, ras_count}, 1);
        chk("post_rst_ra", {16'b0, ReturnAddress}, 16'h0077);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
